// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared game constants: controller state encoding and state/counter widths.
// ----------------------------------------------------------------------------
package game_pkg;

    localparam int unsigned STATE_W = 3;
    // Hold counter is wide enough for any legal reset_pulse length (1..255)
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        StMenu    = 3'd0,
        StArm     = 3'd1,
        StPlay    = 3'd2,
        StPause   = 3'd3,
        StRespawn = 3'd4,
        StWin     = 3'd5,
        StOver    = 3'd6
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, counter debouncer and rising-edge press pulse for one
// raw asynchronous button.
// Ports:
//   clk      - system clock
//   rst_n    - asynchronous active-low reset
//   i_btn    - raw button level (asynchronous)
//   o_press  - one-cycle pulse when the debounced level rises
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC < 2) ? 1 : $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    logic w_differ;
    logic w_accept;

    // r_cnt counts how many consecutive samples already disagreed with the
    // debounced level; the DEBOUNCE_CYC-th disagreeing sample flips it.
    always_comb begin
        w_differ = (r_sync2 != r_level);
        w_accept = w_differ && (r_cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
// Top-level game controller: debounced start/pause buttons, game FSM, entity
// reset hold counter, lives and level bookkeeping.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start_button   - raw start/restart button
//   pause_button   - raw pause/resume button
//   snake_len      - current snake length
//   collision      - collision flag
//   ctrl_state     - current FSM state encoding
//   system_active  - high only while playing
//   reset_pulse    - entity reset, high in ARM and RESPAWN
//   lives, level   - remaining lives, current level
// ----------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned GRID_SIZE    = 100,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned RESET_HOLD   = 15,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned LEVEL_STEP   = 10,
    parameter int unsigned MAX_LEVEL    = 7
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_button,
    input  logic                             pause_button,
    input  logic [$clog2(GRID_SIZE+1)-1:0]   snake_len,
    input  logic                             collision,
    output logic [STATE_W-1:0]               ctrl_state,
    output logic                             system_active,
    output logic                             reset_pulse,
    output logic [$clog2(LIVES+1)-1:0]       lives,
    output logic [$clog2(MAX_LEVEL+1)-1:0]   level
);

    localparam int unsigned LF_W = $clog2(LIVES + 1);
    localparam int unsigned LV_W = $clog2(MAX_LEVEL + 1);

    logic w_start_press;
    logic w_pause_press;

    state_e            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic [LF_W-1:0]   r_lives;
    logic [LV_W-1:0]   r_level;

    state_e            w_state_next;
    logic [HOLD_W-1:0] w_hold_next;
    logic [LF_W-1:0]   w_lives_next;
    logic [LV_W-1:0]   w_level_next;

    logic [31:0]       w_quot;
    logic [LV_W-1:0]   w_level_target;
    logic [LV_W-1:0]   w_level_play;
    logic              w_grid_full;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_start_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (start_button),
        .o_press (w_start_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_pause_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (pause_button),
        .o_press (w_pause_press)
    );

    // Level candidate: saturated snake_len/LEVEL_STEP, never below current level
    always_comb begin
        w_quot         = 32'(snake_len) / LEVEL_STEP;
        w_level_target = (w_quot >= MAX_LEVEL) ? LV_W'(MAX_LEVEL) : LV_W'(w_quot);
        w_level_play   = (w_level_target > r_level) ? w_level_target : r_level;
        w_grid_full    = (32'(snake_len) >= GRID_SIZE);
    end

    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold;
        w_lives_next = r_lives;
        w_level_next = r_level;
        case (r_state)
            StMenu: begin
                if (w_start_press) begin
                    w_state_next = StArm;
                    w_lives_next = LF_W'(LIVES);
                    w_level_next = '0;
                    w_hold_next  = HOLD_W'(RESET_HOLD);
                end
            end
            StArm, StRespawn: begin
                w_hold_next = r_hold - 1'b1;
                // <= 1 also recovers from a corrupted zero count
                if (r_hold <= HOLD_W'(1)) begin
                    w_state_next = StPlay;
                    w_hold_next  = '0;
                end
            end
            StPlay: begin
                w_level_next = w_level_play;
                if (w_grid_full) begin
                    w_state_next = StWin;
                end else if (collision) begin
                    if (r_lives <= LF_W'(1)) begin
                        w_state_next = StOver;
                        w_lives_next = '0;
                    end else begin
                        w_state_next = StRespawn;
                        w_lives_next = r_lives - 1'b1;
                        w_hold_next  = HOLD_W'(RESET_HOLD);
                    end
                end else if (w_pause_press) begin
                    w_state_next = StPause;
                end
            end
            StPause: begin
                if (w_start_press || w_pause_press) begin
                    w_state_next = StPlay;
                end
            end
            StWin, StOver: begin
                if (w_start_press) begin
                    w_state_next = StMenu;
                end
            end
            default: begin
                w_state_next = StMenu;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StMenu;
            r_hold  <= '0;
            r_lives <= '0;
            r_level <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_lives <= w_lives_next;
            r_level <= w_level_next;
        end
    end

    assign ctrl_state    = r_state;
    assign system_active = (r_state == StPlay);
    assign reset_pulse   = (r_state == StArm) || (r_state == StRespawn);
    assign lives         = r_lives;
    assign level         = r_level;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter GRID_SIZE, default 100, snake length at which the game is won.
REQ-002 Parameter DEBOUNCE_CYC, default 4, consecutive stable synchronised samples required to accept a button level.
REQ-003 Parameter RESET_HOLD, default 15, reset_pulse length in cycles; legal range 1..255.
REQ-004 Parameter LIVES, default 3, lives per game; minimum 1.
REQ-005 Parameter LEVEL_STEP, default 10, snake-length increment per level.
REQ-006 Parameter MAX_LEVEL, default 7, level saturation value.
REQ-007 clk  input  1  single clock for all logic.
REQ-008 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-009 start_button  input  1  raw start/restart button, asynchronous.
REQ-010 pause_button  input  1  raw pause/resume button, asynchronous.
REQ-011 snake_len  input  $clog2(GRID_SIZE+1)  current snake length, synchronous to clk.
REQ-012 collision  input  1  single-cycle or level collision flag, synchronous.
REQ-013 ctrl_state  output  3  current FSM state encoding.
REQ-014 system_active  output  1  high only in PLAY.
REQ-015 reset_pulse  output  1  entity reset, high only in ARM and RESPAWN.
REQ-016 lives  output  $clog2(LIVES+1)  remaining lives.
REQ-017 level  output  $clog2(MAX_LEVEL+1)  current level.

Function
REQ-018 Each button: 2-flop synchroniser, then debouncer; debounced level changes only after DEBOUNCE_CYC consecutive equal synchronised samples; press = one-cycle pulse on debounced rising edge.
REQ-019 States/encoding: MENU=0, ARM=1, PLAY=2, PAUSE=3, RESPAWN=4, WIN=5, OVER=6; encoding 7 -> MENU next cycle.
REQ-020 MENU: start press -> ARM; lives<=LIVES, level<=0, hold counter<=RESET_HOLD; pause press ignored.
REQ-021 ARM/RESPAWN: hold counter decrements each cycle; state exits to PLAY on the cycle counter==1, so reset_pulse is high exactly RESET_HOLD cycles; button presses ignored.
REQ-022 PLAY priority, highest first: snake_len>=GRID_SIZE -> WIN; collision with lives==1 -> OVER, lives<=0; collision with lives>1 -> RESPAWN, lives-1, counter<=RESET_HOLD; pause press -> PAUSE; start press ignored.
REQ-023 PLAY level update each cycle: level <= max(level, min(snake_len/LEVEL_STEP, MAX_LEVEL)); never decreases within a game; held in other states.
REQ-024 PAUSE: start or pause press (either or both same cycle) -> PLAY; collision and snake_len ignored.
REQ-025 WIN/OVER: start press -> MENU; lives and level held for display until the next ARM.
REQ-026 system_active and reset_pulse combinational decodes of registered state; glitch-free, no input-to-output combinational path.
REQ-027 State transitions at most one per cycle; press pulses not consumed in the current state are discarded, never queued.

Reset
REQ-028 rst_n low, asynchronously: state MENU, ctrl_state=0, system_active=0, reset_pulse=0, lives=0, level=0, hold counter=0, synchroniser/debouncer flops and debounced levels 0.
REQ-029 Reset asserted mid-game (any state) aborts immediately; after release a fresh debounced start press is required to leave MENU.

Structure
REQ-030 State encodings and state width shared via package game_pkg, alongside any existing game constants.
REQ-031 One sub-module btn_debounce (synchroniser + DEBOUNCE_CYC counter + edge pulse), instantiated twice.
REQ-032 FSM, hold counter, lives and level registers in game_sequencer; no further hierarchy.

Verification (defaults unless stated)
REQ-033 Reset release, start held 8 cycles -> one press pulse; ARM; reset_pulse high exactly 15 cycles; PLAY with lives=3, level=0.
REQ-034 Start toggling every 2 cycles for 20 cycles in MENU -> no press, state stays MENU.
REQ-035 PLAY, three collision pulses, each after RESPAWN completes -> lives 3->2->1->0; first two enter RESPAWN with 15-cycle reset_pulse; third enters OVER with no reset_pulse.
REQ-036 PLAY, snake_len=100 and collision same cycle -> WIN, lives unchanged; snake_len 35 then 20 -> level 3 held; snake_len 95 -> level 7 (saturated).
REQ-037 PLAY, pause press -> PAUSE, system_active=0; collision in PAUSE -> no change; start press -> PLAY.
REQ-038 rst_n pulsed low during RESPAWN cycle 5 -> all outputs zero immediately, state MENU after release; RESET_HOLD=1 rebuild -> reset_pulse exactly 1 cycle.
